mb_lane_deser: RTL and testbench
================================

// Module: mb_lane_deser
// PURPOSE
//  Multi-lane mainband receive deserializer, fully in the pll_clk domain. Each lane delivers
//  2 bits per pll_clk (DDR pair already captured by the AFE: even = ckp-edge bit, odd = ckn-edge
//  bit, even is earlier in time). Bits accumulate into WORD_W-bit words per lane. Completed
//  multi-lane words go into a FIFO_DEPTH-entry buffer, drained by the mainband digital logic
//  over a valid/ready handshake. Overflow and partial-word drops are flagged.
// PARAMETERS
//  NUM_LANES   16  number of data lanes
//  WORD_W      32  bits per lane per word; even, >= 4
//  FIFO_DEPTH  4   output buffer entries; power of 2, >= 2
//  MSB_FIRST   1   1: first received bit lands in bit WORD_W-1; 0: first bit lands in bit 0
// PORTS
//  pll_clk         in   1                  clock
//  i_rst_n         in   1                  asynchronous reset, active-low
//  i_ser_valid     in   1                  current beat (even/odd pairs) is valid
//  i_data_even     in   NUM_LANES          bit sampled on ckp edge, per lane
//  i_data_odd      in   NUM_LANES          bit sampled on ckn edge, per lane
//  i_flush         in   1                  discard the partial word in progress
//  i_par_ready     in   1                  consumer accepts the FIFO head
//  o_par_data      out  NUM_LANES*WORD_W   FIFO head; lane k occupies [k*WORD_W +: WORD_W]
//  o_par_valid     out  1                  FIFO non-empty
//  o_fifo_level    out  $clog2(FIFO_DEPTH)+1  occupied entries
//  o_overflow      out  1                  sticky: a completed word was dropped (FIFO full)
//  o_partial_drop  out  1                  1-cycle pulse: flush discarded >= 1 beat
// BEHAVIOUR
//  Reset is i_rst_n, asynchronous, active-low; clock is pll_clk. Reset clears all state.
//  All outputs are 0 in reset. Reset mid-word or mid-drain discards everything, with no pulses.
//  Beat counter beat_cnt runs 0..WORD_W/2-1. It increments on each pll_clk with i_ser_valid=1
//   and i_flush=0, then wraps to 0. Idle cycles (i_ser_valid=0) hold the counter and shift regs.
//  Shift per valid beat, per lane:
//   MSB_FIRST=1: sr <= {sr[WORD_W-3:0], even, odd}
//   MSB_FIRST=0: sr <= {odd, even, sr[WORD_W-1:2]}
//  Completion: the valid beat with beat_cnt==WORD_W/2-1. The completed word (including this beat)
//   is written to the FIFO at the same edge. o_par_valid rises 1 cycle after the last beat edge.
//  Pop: o_par_valid & i_par_ready at an edge. FIFO is strict in-order.
//  o_par_data is forced to 0 whenever o_par_valid=0.
//  Push into a full FIFO:
//   - if a pop happens at the same edge, the push is accepted and level stays FIFO_DEPTH;
//   - otherwise the word is dropped, FIFO contents are unchanged, and o_overflow is set
//     (cleared only by reset).
//  Push and pop at the same edge when not full: level is unchanged.
//  i_flush=1: beat_cnt <= 0 and the current beat is discarded (flush beats i_ser_valid).
//   o_partial_drop pulses the next cycle if beat_cnt!=0 or i_ser_valid=1.
//   The FIFO is untouched by flush.
//  Completion and flush at the same edge: flush wins, no push.
//  Pointers are $clog2(FIFO_DEPTH)+1 bits and wrap naturally. Level = wr_ptr - rd_ptr.
// TESTING
//  1 Defaults, lane0 pattern 0xA5A50F0F MSB first over 16 consecutive beats, other lanes 0
//    -> o_par_valid=1 one cycle after beat 16; lane0=0xA5A50F0F; level=1.
//  2 MSB_FIRST=0, same bit stream
//    -> lane0 equals the bit-reverse of 0xA5A50F0F, i.e. 0xF0F0A5A5.
//  3 i_ser_valid with random 1-3 cycle gaps inside a word
//    -> identical word to test 1; no early valid.
//  4 i_par_ready=0, push 5 words W0..W4
//    -> level=4, o_overflow=1 after W4; on ready=1 the output is W0..W3 in order, then empty.
//  5 Flush after 5 beats
//    -> o_partial_drop 1-cycle pulse; the next 16 beats give a clean word; level unchanged by flush.
//  6 Full FIFO with i_par_ready=1 on the completion edge
//    -> push accepted, no overflow, level stays 4.
//    Assert i_rst_n=0 mid-word -> all outputs 0; the next full word decodes correctly.

Source files
------------

// File: rtl/mb_lane_deser.sv
// mb_lane_deser: multi-lane DDR-pair deserializer feeding a small in-order output FIFO
module mb_lane_deser #(
    parameter int NUM_LANES  = 16,
    parameter int WORD_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                                 pll_clk,
    input  logic                                 i_rst_n,
    input  logic                                 i_ser_valid,
    input  logic [NUM_LANES-1:0]                 i_data_even,
    input  logic [NUM_LANES-1:0]                 i_data_odd,
    input  logic                                 i_flush,
    input  logic                                 i_par_ready,
    output logic [NUM_LANES*WORD_W-1:0]          o_par_data,
    output logic                                 o_par_valid,
    output logic [$clog2(FIFO_DEPTH):0]          o_fifo_level,
    output logic                                 o_overflow,
    output logic                                 o_partial_drop
);
    localparam int HB = WORD_W / 2;
    localparam int BW = $clog2(HB);
    localparam int PW = $clog2(FIFO_DEPTH) + 1;
    localparam int AW = PW - 1;
    localparam int DW = NUM_LANES * WORD_W;
    localparam logic [BW-1:0] LAST = BW'(HB - 1);
    localparam logic [PW-1:0] FULL = PW'(FIFO_DEPTH);

    logic [BW-1:0] beat_cnt;
    logic [DW-1:0] sr, sr_nxt;
    logic [DW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          full, pop, push_req, push_ok;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        if (MSB_FIRST) begin : g_msb
            assign sr_nxt[k*WORD_W +: WORD_W] = {sr[k*WORD_W +: WORD_W-2], i_data_even[k], i_data_odd[k]};
        end else begin : g_lsb
            assign sr_nxt[k*WORD_W +: WORD_W] = {i_data_odd[k], i_data_even[k], sr[k*WORD_W+2 +: WORD_W-2]};
        end
    end

    assign o_fifo_level = wr_ptr - rd_ptr;
    assign o_par_valid  = o_fifo_level != '0;
    assign o_par_data   = o_par_valid ? mem[rd_ptr[AW-1:0]] : '0;
    assign full         = o_fifo_level == FULL;
    assign pop          = o_par_valid & i_par_ready;
    assign push_req     = i_ser_valid & ~i_flush & (beat_cnt == LAST);
    assign push_ok      = push_req & (~full | pop);

    // Beat counting and lane shifting; flush discards the beat and restarts the word
    always_ff @(posedge pll_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            beat_cnt       <= '0;
            sr             <= '0;
            o_partial_drop <= 1'b0;
        end else begin
            o_partial_drop <= i_flush & ((beat_cnt != '0) | i_ser_valid);
            if (i_flush) begin
                beat_cnt <= '0;
            end else if (i_ser_valid) begin
                beat_cnt <= (beat_cnt == LAST) ? '0 : beat_cnt + BW'(1);
                sr       <= sr_nxt;
            end
        end
    end

    // Output FIFO: a full FIFO still accepts a push when the head pops on the same edge
    always_ff @(posedge pll_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr[AW-1:0]] <= sr_nxt;
                wr_ptr              <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            if (push_req & ~push_ok) o_overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mb_lane_deser.sv
// tb_mb_lane_deser: directed + random checks of MSB-first and LSB-first deserializers against a bit-placement model
module tb_mb_lane_deser;
    localparam int NL = 16;
    localparam int W  = 32;
    localparam int D  = 4;
    localparam int DW = NL * W;
    localparam int LW = $clog2(D) + 1;

    logic          pll_clk = 1'b0;
    logic          i_rst_n = 1'b1;
    logic          i_ser_valid = 1'b0;
    logic          i_flush = 1'b0;
    logic          i_par_ready = 1'b0;
    logic [NL-1:0] i_data_even = '0;
    logic [NL-1:0] i_data_odd = '0;
    logic [DW-1:0] dm, dl;
    logic          vm, vl, om, ol, pm, pl;
    logic [LW-1:0] lm, ll;

    always #5 pll_clk = ~pll_clk;

    mb_lane_deser #(.NUM_LANES(NL), .WORD_W(W), .FIFO_DEPTH(D), .MSB_FIRST(1'b1)) dut (
        .pll_clk(pll_clk), .i_rst_n(i_rst_n), .i_ser_valid(i_ser_valid),
        .i_data_even(i_data_even), .i_data_odd(i_data_odd), .i_flush(i_flush),
        .i_par_ready(i_par_ready), .o_par_data(dm), .o_par_valid(vm),
        .o_fifo_level(lm), .o_overflow(om), .o_partial_drop(pm));

    mb_lane_deser #(.NUM_LANES(NL), .WORD_W(W), .FIFO_DEPTH(D), .MSB_FIRST(1'b0)) dut_lsb (
        .pll_clk(pll_clk), .i_rst_n(i_rst_n), .i_ser_valid(i_ser_valid),
        .i_data_even(i_data_even), .i_data_odd(i_data_odd), .i_flush(i_flush),
        .i_par_ready(i_par_ready), .o_par_data(dl), .o_par_valid(vl),
        .o_fifo_level(ll), .o_overflow(ol), .o_partial_drop(pl));

    int checks = 0;
    int failures = 0;

    // Reference model: bits are placed by their position in the word, words queued in order
    logic [DW-1:0] qm[$];
    logic [DW-1:0] ql[$];
    logic [DW-1:0] cur_m = '0;
    logic [DW-1:0] cur_l = '0;
    int            nbits = 0;
    bit            ovf = 1'b0;
    bit            pdrop = 1'b0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs();
        logic [DW-1:0] hm, hl;
        hm = (qm.size() != 0) ? qm[0] : '0;
        hl = (ql.size() != 0) ? ql[0] : '0;
        chk("valid", DW'(vm), DW'(qm.size() != 0));
        chk("valid_lsb", DW'(vl), DW'(ql.size() != 0));
        chk("level", DW'(lm), DW'(qm.size()));
        chk("level_lsb", DW'(ll), DW'(ql.size()));
        chk("data_msb", dm, hm);
        chk("data_lsb", dl, hl);
        chk("overflow", DW'(om), DW'(ovf));
        chk("overflow_lsb", DW'(ol), DW'(ovf));
        chk("partial_drop", DW'(pm), DW'(pdrop));
        chk("partial_drop_lsb", DW'(pl), DW'(pdrop));
    endtask

    task automatic step(input bit v, input bit f, input bit r, input logic [NL-1:0] ev, input logic [NL-1:0] od);
        bit pop, push;
        i_ser_valid = v;
        i_flush     = f;
        i_par_ready = r;
        i_data_even = ev;
        i_data_odd  = od;
        pop   = (qm.size() != 0) && r;
        pdrop = f && (nbits != 0 || v);
        push  = 1'b0;
        if (f) begin
            nbits = 0;
        end else if (v) begin
            for (int k = 0; k < NL; k++) begin
                cur_m[k*W + W-1-nbits] = ev[k];
                cur_m[k*W + W-2-nbits] = od[k];
                cur_l[k*W + nbits]     = ev[k];
                cur_l[k*W + nbits + 1] = od[k];
            end
            nbits += 2;
            if (nbits == W) begin
                push  = 1'b1;
                nbits = 0;
            end
        end
        if (pop) begin
            qm.delete(0);
            ql.delete(0);
        end
        if (push) begin
            if (qm.size() < D) begin
                qm.push_back(cur_m);
                ql.push_back(cur_l);
            end else begin
                ovf = 1'b1;
            end
        end
        @(posedge pll_clk);
        #1;
        check_outs();
    endtask

    task automatic idle(input bit r);
        step(1'b0, 1'b0, r, NL'($urandom), NL'($urandom));
    endtask

    task automatic do_reset();
        #2;
        i_rst_n     = 1'b0;
        i_ser_valid = 1'b0;
        i_flush     = 1'b0;
        i_par_ready = 1'b0;
        qm.delete();
        ql.delete();
        nbits = 0;
        ovf   = 1'b0;
        pdrop = 1'b0;
        #1;
        check_outs();
        @(posedge pll_clk);
        #1;
        i_rst_n = 1'b1;
    endtask

    task automatic pat_word(input logic [31:0] p, input bit gaps);
        for (int b = 0; b < 16; b++) begin
            if (gaps && b > 0) begin
                int n;
                n = $urandom_range(1, 3);
                for (int g = 0; g < n; g++) idle(1'b0);
            end
            step(1'b1, 1'b0, 1'b0, NL'(p[31-2*b]), NL'(p[30-2*b]));
        end
    endtask

    task automatic rand_word(input bit ready_last);
        for (int b = 0; b < 16; b++)
            step(1'b1, 1'b0, (b == 15) ? ready_last : 1'b0, NL'($urandom), NL'($urandom));
    endtask

    initial begin
        @(posedge pll_clk);
        #1;
        do_reset();

        pat_word(32'hA5A50F0F, 1'b0);
        chk("t1_lane0_msb", DW'(dm[31:0]), DW'(32'hA5A50F0F));
        chk("t2_lane0_lsb", DW'(dl[31:0]), DW'(32'hF0F0A5A5));
        chk("t1_level", DW'(lm), DW'(1));
        idle(1'b1);

        pat_word(32'hA5A50F0F, 1'b1);
        chk("t3_lane0_msb", DW'(dm[31:0]), DW'(32'hA5A50F0F));
        idle(1'b1);

        for (int b = 0; b < 5; b++) step(1'b1, 1'b0, 1'b0, NL'($urandom), NL'($urandom));
        step(1'b1, 1'b1, 1'b0, NL'($urandom), NL'($urandom));
        chk("t5_pulse", DW'(pm), DW'(1));
        idle(1'b0);
        chk("t5_pulse_end", DW'(pm), DW'(0));
        step(1'b0, 1'b1, 1'b0, '0, '0);
        chk("t5_no_pulse_empty", DW'(pm), DW'(0));
        rand_word(1'b0);
        chk("t5_level", DW'(lm), DW'(1));
        idle(1'b1);

        for (int w = 0; w < 5; w++) rand_word(1'b0);
        chk("t4_level", DW'(lm), DW'(4));
        chk("t4_overflow", DW'(om), DW'(1));
        for (int i = 0; i < 5; i++) idle(1'b1);
        chk("t4_empty", DW'(vm), DW'(0));

        do_reset();
        for (int w = 0; w < 4; w++) rand_word(1'b0);
        rand_word(1'b1);
        chk("t6_level", DW'(lm), DW'(4));
        chk("t6_no_overflow", DW'(om), DW'(0));
        idle(1'b1);
        idle(1'b1);
        for (int b = 0; b < 7; b++) step(1'b1, 1'b0, 1'b0, NL'($urandom), NL'($urandom));
        do_reset();
        pat_word(32'hA5A50F0F, 1'b0);
        chk("t6_after_reset_lane0", DW'(dm[31:0]), DW'(32'hA5A50F0F));
        chk("t6_after_reset_lsb", DW'(dl[31:0]), DW'(32'hF0F0A5A5));

        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0, $urandom_range(0, 2) == 0,
                 NL'($urandom), NL'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
